// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART framers (RX now, TX later).
//   rx_state_t   : receive framer state encoding
//   OVERSAMPLE   : sample ticks per bit
//   DIV_DEFAULT  : clk cycles per oversample tick at the default clock/baud
//   calc_div()   : rounds clk_hz / (baud * OVERSAMPLE) to the nearest integer
package uart_pkg;

  localparam int OVERSAMPLE     = 16;
  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int BAUD_DEFAULT   = 115_200;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  localparam int DIV_DEFAULT = calc_div(CLK_HZ_DEFAULT, BAUD_DEFAULT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Oversample tick generator: counts 0..DIV-1 and flags tick on DIV-1.
// restart forces the count back to 0 so the tick phase can be aligned to an
// external event (the detected start edge on RX).
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   restart : synchronous counter clear
//   tick    : high for one cycle every DIV cycles
module baud_tick_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// 16x oversampling UART receiver feeding a FIFO write port. Default frame is
// 8N1; defining UART_RX_PARITY_EN adds an even parity bit (8E1). The port
// list is the same in both builds; parity_err is tied low without parity.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   rx_i       : raw serial line, idle high, asynchronous to clk
//   full       : FIFO full flag, sampled with the stop bit
//   wr_en      : one-cycle FIFO write strobe
//   wr_data    : received data, held until the next write
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, good byte dropped because full was set
//   busy       : high whenever the framer is not idle
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | validating start bit at its middle (sc=7)
// DATA    | sampling data bits at sc=15, LSB first
// PARITY  | sampling the even parity bit (parity build only)
// STOP    | sampling stop bit; write, overrun, parity or framing outcome
// WAIT_HI | after a framing error, wait for the line to return high
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int DIV       = DIV_DEFAULT,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  input  logic                 full,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BCW = $clog2(DATA_BITS + 1);

  rx_state_t            state;
  logic                 rx_m;
  logic                 rx_s;
  logic [3:0]           sc;
  logic [BCW-1:0]       bc;
  logic [DATA_BITS-1:0] sr;
  logic                 tick;
  logic                 restart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  // Realigning the tick phase to the start edge puts every sample 8 ticks
  // after the edge plus a whole number of bits, i.e. mid bit.
  assign restart = (state == IDLE) && !rx_s;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sc        <= '0;
      bc        <= '0;
      sr        <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            sc    <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (sc == 4'd7) begin
              if (rx_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
                sc    <= '0;
                bc    <= '0;
              end
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == 4'd15) begin
              sr <= {rx_s, sr[DATA_BITS-1:1]};
              bc <= bc + BCW'(1);
              if (bc == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == 4'd15) begin
              par_bad <= rx_s ^ (^sr);
              state   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            sc <= sc + 4'd1;
            if (sc == 4'd15) begin
              if (!rx_s) begin
                // Framing error wins over parity; hold off until the line
                // recovers so a break cannot look like a start bit.
                frame_err <= 1'b1;
                state     <= WAIT_HI;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (par_bad) begin
                  parity_err <= 1'b1;
                end else
`endif
                if (full) begin
                  overrun <= 1'b1;
                end else begin
                  wr_en   <= 1'b1;
                  wr_data <= sr;
                end
              end
            end
          end
        end
        WAIT_HI: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;

  localparam int DIV = 4;
  localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Edge to wr_en: 2 synchroniser flops + 1 clk into START, then 8 ticks to
  // mid start bit and 16 ticks per data/parity/stop bit.
  localparam int LAT = 3 + DIV * 8 + DIV * 16 * (8 + PBITS + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       full;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  uart_rx_framer #(.DIV(DIV), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .full       (full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         n_wr = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  logic [7:0] q_data[$];
  int         last_wr_cyc = 0;
  logic       busy_at_wr = 1'b1, busy_before_wr = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      q_data.push_back(wr_data);
      last_wr_cyc = cyc;
      busy_at_wr = busy;
      busy_before_wr = prev_busy;
    end
    if (frame_err)  n_fe++;
    if (parity_err) n_pe++;
    if (overrun)    n_ov++;
    prev_busy = busy;
  end

  int total = 0;
  int bad = 0;
  int e_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  // Start bit, data LSB first, and the parity bit when enabled.
  task automatic send_head(input logic [7:0] d, input logic p);
    rx_i = 1'b0;
    e_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = p;
    repeat (BIT) @(negedge clk);
`else
    if (p) rx_i = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, ^d);
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  int b_wr, b_fe, b_pe, b_ov, b_q;

  task automatic snap();
    b_wr = n_wr; b_fe = n_fe; b_pe = n_pe; b_ov = n_ov; b_q = q_data.size();
  endtask

  initial begin
    rst  = 1'b0;
    rx_i = 1'b1;
    full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    idle_bits(4);

    // 0xA5 clean frame
    snap();
    send_frame(8'hA5);
    idle_bits(2);
    check("a5_writes", n_wr - b_wr, 1);
    check("a5_data", q_data[b_q], 8'hA5);
    check("a5_errors", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);
    check("a5_latency", last_wr_cyc - e_cyc, LAT);
    check("a5_busy_before_wr", busy_before_wr, 1);
    check("a5_busy_at_wr", busy_at_wr, 0);

    // 20-clk low glitch
    snap();
    rx_i = 1'b0;
    e_cyc = cyc;
    repeat (10) @(negedge clk);
    check("glitch_busy_start", busy, 1);
    repeat (10) @(negedge clk);
    rx_i = 1'b1;
    // mid start bit is 8 ticks (32 clk) plus 3 clk of synchroniser/entry
    repeat (16) @(negedge clk);
    check("glitch_idle", busy, 0);
    idle_bits(12);
    check("glitch_writes", n_wr - b_wr, 0);
    check("glitch_errors", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);

    // 0x3C with stop held low for 3 bits
    snap();
    send_head(8'h3C, ^8'h3C);
    rx_i = 1'b0;
    repeat (3 * BIT - 1) @(negedge clk);
    check("brk_busy_low", busy, 1);
    check("brk_frame_err", n_fe - b_fe, 1);
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_released", busy, 0);
    idle_bits(2);
    check("brk_frame_err_once", n_fe - b_fe, 1);
    check("brk_writes", n_wr - b_wr, 0);
    check("brk_other_errors", (n_pe - b_pe) + (n_ov - b_ov), 0);

    // 0x55 with FIFO full, then 0x0F with room
    snap();
    full = 1'b1;
    send_frame(8'h55);
    idle_bits(1);
    full = 1'b0;
    check("full_overrun", n_ov - b_ov, 1);
    check("full_writes", n_wr - b_wr, 0);
    check("full_other_errors", (n_fe - b_fe) + (n_pe - b_pe), 0);
    snap();
    send_frame(8'h0F);
    idle_bits(2);
    check("after_full_writes", n_wr - b_wr, 1);
    check("after_full_data", q_data[b_q], 8'h0F);

    // back-to-back 0x00, 0xFF
    snap();
    send_frame(8'h00);
    send_frame(8'hFF);
    idle_bits(2);
    check("b2b_writes", n_wr - b_wr, 2);
    check("b2b_first", q_data[b_q], 8'h00);
    check("b2b_second", q_data[b_q + 1], 8'hFF);
    check("b2b_errors", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);

    // reset mid-data of 0x81 (during bit 7, which is high)
    snap();
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx_i = (i == 0);
      repeat (BIT) @(negedge clk);
    end
    rx_i = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wr_data", wr_data, 0);
    check("rst_mid_wr_en", wr_en, 0);
    @(negedge clk);
    rst = 1'b1;
    idle_bits(4);
    check("rst_mid_writes", n_wr - b_wr, 0);
    check("rst_mid_errors", (n_fe - b_fe) + (n_pe - b_pe) + (n_ov - b_ov), 0);
    snap();
    send_frame(8'h7E);
    idle_bits(2);
    check("post_rst_writes", n_wr - b_wr, 1);
    check("post_rst_data", q_data[b_q], 8'h7E);

`ifdef UART_RX_PARITY_EN
    snap();
    send_head(8'h03, 1'b1);
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk);
    idle_bits(2);
    check("par_bad_err", n_pe - b_pe, 1);
    check("par_bad_writes", n_wr - b_wr, 0);
    snap();
    send_head(8'h03, 1'b0);
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk);
    idle_bits(2);
    check("par_ok_writes", n_wr - b_wr, 1);
    check("par_ok_data", q_data[b_q], 8'h03);
    check("par_ok_err", n_pe - b_pe, 0);
`else
    check("no_parity_err_ever", n_pe, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
